ascon_ctrl: RTL and testbench
=============================

# ascon_ctrl

Moore control FSM driving the ASCON-128 permutation datapath stage (mux → xor_begin → p → xor_end → dff) that sits directly downstream of it. It sequences initialisation, one associated-data block, NB_PT_BLOCKS plaintext blocks and finalisation, one permutation round per clock. It also produces the per-round select, enable, XOR-control and round-index signals, the 64-bit data handshake, and the capture strobes for the ciphertext and tag registers.

## Interface
- NB_PT_BLOCKS, default 4: number of 64-bit plaintext blocks per message, legal range 1..15.
- clock_i  in  1  single clock; all state updates on the rising edge.
- resetb_i  in  1  asynchronous active-low reset.
- start_i  in  1  begin a message; sampled only in IDLE.
- data_valid_i  in  1  upstream 64-bit AD/plaintext word is present on the datapath data bus.
- data_ready_o  out  1  word consumed this cycle; single-cycle pulse.
- select_o  out  1  0 = load the external initial state (IV‖K‖N), 1 = feed back the register.
- enable_o  out  1  state register enable.
- xor_data_begin_o  out  1  XOR the data word into x0 before the round.
- xor_key_begin_o  out  1  XOR 0‖K‖0 before the round.
- xor_key_end_o  out  1  XOR K into the last 128 bits after the round.
- xor_ext_end_o  out  1  XOR the domain-separation bit into the LSB after the round.
- round_o  out  4  ASCON round-constant index, 0..11.
- cipher_valid_o  out  1  capture strobe for the ciphertext register.
- tag_valid_o  out  1  capture strobe for the tag register.
- busy_o  out  1  high from leaving IDLE until returning to IDLE.
- done_o  out  1  end-of-message pulse.

## Operation
- **States:** IDLE, INIT, WAIT_AD, AD, WAIT_PT, PT, FINAL, TAG.
- **Counters:**
  - 4-bit round counter `rnd`.
  - 4-bit block counter `blk` counting processed plaintext blocks.
- **Default outputs:** every output is 0 unless stated below. select_o is 1 in every state except IDLE and the first INIT cycle.
- **IDLE:**
  - On start_i=1, go to INIT with rnd=0.
  - start_i outside IDLE is ignored.
- **INIT:**
  - enable_o=1, round_o=rnd, select_o=0 only when rnd=0.
  - rnd increments 0→11.
  - At rnd=11, xor_key_end_o=1, then go to WAIT_AD.
- **WAIT_AD / WAIT_PT:** enable_o=0 and the state is held. When data_valid_i=1, go to AD / PT:
  - Target rnd=6.
  - From WAIT_PT with blk=NB_PT_BLOCKS-1, go to FINAL with rnd=0 instead.
- **AD:**
  - enable_o=1, round_o=rnd, rnd increments 6→11.
  - First cycle (rnd=6): xor_data_begin_o=1, data_ready_o=1.
  - At rnd=11: xor_ext_end_o=1, blk←0, go to WAIT_PT.
- **PT:**
  - enable_o=1, round_o=rnd, rnd increments 6→11.
  - First cycle: xor_data_begin_o=1, data_ready_o=1, cipher_valid_o=1.
  - At rnd=11: blk increments, go to WAIT_PT.
- **FINAL:**
  - enable_o=1, round_o=rnd, rnd increments 0→11.
  - First cycle: xor_data_begin_o=1, xor_key_begin_o=1, data_ready_o=1, cipher_valid_o=1 (last plaintext block).
  - At rnd=11: xor_key_end_o=1, go to TAG.
- **TAG:**
  - tag_valid_o=1, done_o=1, enable_o=0 (register holds state ⊕ key, whose last 128 bits are the tag).
  - Next state IDLE.
- **Boundary cases:**
  - NB_PT_BLOCKS=1: WAIT_PT goes straight to FINAL; PT is never entered.
  - Counters never wrap past 11: rnd is reloaded on every state entry.
  - data_valid_i dropping mid-block has no effect; it is sampled only in WAIT states.
- **Reset:** resetb_i low at any time, including mid-round, forces IDLE asynchronously with rnd=0, blk=0 and all outputs 0.

## Timing
- All outputs are decoded from registered state and counters only (Moore); nothing depends combinationally on an input.
- start_i sampled high at edge n → first INIT round cycle (select_o=0) is cycle n+1.
- With data_valid_i held high, the WAIT states last exactly 1 cycle. Total from start_i to done_o:
  - 12 cycles INIT
  - 1 cycle WAIT_AD
  - 6 cycles AD
  - 1 cycle WAIT_PT
  - (NB_PT_BLOCKS-1) PT blocks of 7 cycles each (1 WAIT_PT + 6 PT)
  - 12 cycles FINAL
  - 1 cycle TAG
  - NB_PT_BLOCKS=4: 54 cycles, with done_o in cycle n+54.
- data_ready_o pulses exactly once per consumed word: NB_PT_BLOCKS+1 pulses per message.
- busy_o is registered: high from cycle n+1 through the TAG cycle.

## Test plan
- Reset during INIT at rnd=5 → same cycle: all outputs 0, busy_o=0. A new start_i produces select_o=0, round_o=0 on the next cycle.
- start_i=1 with NB_PT_BLOCKS=4 and data_valid_i tied to 1:
  - round_o sequence is 0..11, 6..11 ×4, 0..11.
  - data_ready_o pulses 5 times; cipher_valid_o pulses 4 times.
  - tag_valid_o and done_o occur in cycle n+54.
- data_valid_i held low for 10 cycles in WAIT_PT → enable_o=0 and round_o is stable throughout; on release, the next cycle has round_o=6, xor_data_begin_o=1.
- NB_PT_BLOCKS=1 → after AD: one WAIT_PT cycle, then FINAL first cycle with xor_data_begin_o=xor_key_begin_o=cipher_valid_o=1, round_o=0.
- start_i pulsed during AD → ignored; sequence and counters are unchanged.
- Check xor_ext_end_o is high only at AD rnd=11, and xor_key_end_o only at INIT rnd=11 and FINAL rnd=11.

Source files
------------

// File: rtl/ascon_ctrl.sv
// ascon_ctrl: Moore control FSM for the ASCON-128 permutation datapath stage.
// Sequences INIT (12 rounds), one AD block (6 rounds), NB_PT_BLOCKS plaintext
// blocks (6 rounds each, the last one absorbed by FINAL's 12 rounds) and TAG.
// Ports:
//   clock_i, resetb_i        clock, asynchronous active-low reset
//   start_i                  begin a message (sampled only in IDLE)
//   data_valid_i             upstream data word present (sampled only in WAIT states)
//   data_ready_o             word consumed this cycle
//   select_o, enable_o       state-register input mux select and enable
//   xor_data_begin_o         XOR data word into x0 before the round
//   xor_key_begin_o          XOR 0||K||0 before the round
//   xor_key_end_o            XOR K into last 128 bits after the round
//   xor_ext_end_o            XOR domain-separation bit after the round
//   round_o                  round-constant index 0..11
//   cipher_valid_o           ciphertext capture strobe
//   tag_valid_o, done_o      tag capture strobe / end-of-message pulse
//   busy_o                   high from leaving IDLE until returning to it
module ascon_ctrl #(
    parameter int NB_PT_BLOCKS = 4
) (
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       start_i,
    input  logic       data_valid_i,
    output logic       data_ready_o,
    output logic       select_o,
    output logic       enable_o,
    output logic       xor_data_begin_o,
    output logic       xor_key_begin_o,
    output logic       xor_key_end_o,
    output logic       xor_ext_end_o,
    output logic [3:0] round_o,
    output logic       cipher_valid_o,
    output logic       tag_valid_o,
    output logic       busy_o,
    output logic       done_o
);
    typedef enum logic [2:0] {IDLE, INIT, WAIT_AD, AD, WAIT_PT, PT, FINAL, TAG} state_t;
    typedef struct packed {
        logic       ready;
        logic       select;
        logic       enable;
        logic       xdb;
        logic       xkb;
        logic       xke;
        logic       xee;
        logic [3:0] round;
        logic       cipher;
        logic       tag;
        logic       busy;
        logic       done;
    } out_t;

    localparam logic [3:0] LAST_BLK = 4'(NB_PT_BLOCKS - 1);

    state_t     state_q, state_d;
    logic [3:0] rnd_q, rnd_d, blk_q, blk_d;
    out_t       out_q, out_d;
    logic       last_rnd, run_d, blk_first_d, fin_first_d;

    assign last_rnd = rnd_q == 4'd11;

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        blk_d   = blk_q;
        case (state_q)
            IDLE:    if (start_i) begin
                state_d = INIT;
                rnd_d   = 4'd0;
            end
            INIT:    if (last_rnd) state_d = WAIT_AD; else rnd_d = rnd_q + 4'd1;
            WAIT_AD: if (data_valid_i) begin
                state_d = AD;
                rnd_d   = 4'd6;
            end
            AD:      if (last_rnd) begin
                state_d = WAIT_PT;
                blk_d   = 4'd0;
            end else rnd_d = rnd_q + 4'd1;
            // The last plaintext block is absorbed by FINAL rather than PT.
            WAIT_PT: if (data_valid_i) begin
                state_d = blk_q == LAST_BLK ? FINAL : PT;
                rnd_d   = blk_q == LAST_BLK ? 4'd0 : 4'd6;
            end
            PT:      if (last_rnd) begin
                state_d = WAIT_PT;
                blk_d   = blk_q + 4'd1;
            end else rnd_d = rnd_q + 4'd1;
            FINAL:   if (last_rnd) state_d = TAG; else rnd_d = rnd_q + 4'd1;
            default: begin
                state_d = IDLE;
                rnd_d   = 4'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so that registering them makes
    // them line up with the state they describe.
    always_comb begin
        run_d       = state_d inside {INIT, AD, PT, FINAL};
        blk_first_d = (state_d == AD || state_d == PT) && rnd_d == 4'd6;
        fin_first_d = state_d == FINAL && rnd_d == 4'd0;
        out_d.ready  = blk_first_d || fin_first_d;
        out_d.select = state_d != IDLE && !(state_d == INIT && rnd_d == 4'd0);
        out_d.enable = run_d;
        out_d.xdb    = blk_first_d || fin_first_d;
        out_d.xkb    = fin_first_d;
        out_d.xke    = (state_d == INIT || state_d == FINAL) && rnd_d == 4'd11;
        out_d.xee    = state_d == AD && rnd_d == 4'd11;
        out_d.round  = run_d ? rnd_d : 4'd0;
        out_d.cipher = (state_d == PT && rnd_d == 4'd6) || fin_first_d;
        out_d.tag    = state_d == TAG;
        out_d.busy   = state_d != IDLE;
        out_d.done   = state_d == TAG;
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q <= IDLE;
            rnd_q   <= '0;
            blk_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            blk_q   <= blk_d;
            out_q   <= out_d;
        end
    end

    assign data_ready_o     = out_q.ready;
    assign select_o         = out_q.select;
    assign enable_o         = out_q.enable;
    assign xor_data_begin_o = out_q.xdb;
    assign xor_key_begin_o  = out_q.xkb;
    assign xor_key_end_o    = out_q.xke;
    assign xor_ext_end_o    = out_q.xee;
    assign round_o          = out_q.round;
    assign cipher_valid_o   = out_q.cipher;
    assign tag_valid_o      = out_q.tag;
    assign busy_o           = out_q.busy;
    assign done_o           = out_q.done;
endmodule

// File: tb/tb_ascon_ctrl.sv
// tb_ascon_ctrl: table-driven and directed checks of ascon_ctrl (NB=4 and NB=1).
module tb_ascon_ctrl;
    typedef struct packed {
        logic [3:0] r;
        logic en, sel, xdb, xkb, xke, xee, dr, cv, tv, dn, bs;
    } exp_t;
    typedef struct {
        logic st;
        logic dv;
        exp_t e;
    } vec_t;

    logic clk = 1'b0, rstn = 1'b0, st = 1'b0, dv = 1'b0, st1 = 1'b0, dv1 = 1'b0;
    logic [3:0] rnd, rnd1;
    logic en, sel, xdb, xkb, xke, xee, dr, cv, tv, dn, bs;
    logic en1, sel1, xdb1, xkb1, xke1, xee1, dr1, cv1, tv1, dn1, bs1;
    exp_t ov, ov1;
    vec_t tbl[$];
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    ascon_ctrl #(.NB_PT_BLOCKS(4)) dut (
        .clock_i(clk), .resetb_i(rstn), .start_i(st), .data_valid_i(dv),
        .data_ready_o(dr), .select_o(sel), .enable_o(en), .xor_data_begin_o(xdb),
        .xor_key_begin_o(xkb), .xor_key_end_o(xke), .xor_ext_end_o(xee),
        .round_o(rnd), .cipher_valid_o(cv), .tag_valid_o(tv), .busy_o(bs), .done_o(dn)
    );

    ascon_ctrl #(.NB_PT_BLOCKS(1)) dut1 (
        .clock_i(clk), .resetb_i(rstn), .start_i(st1), .data_valid_i(dv1),
        .data_ready_o(dr1), .select_o(sel1), .enable_o(en1), .xor_data_begin_o(xdb1),
        .xor_key_begin_o(xkb1), .xor_key_end_o(xke1), .xor_ext_end_o(xee1),
        .round_o(rnd1), .cipher_valid_o(cv1), .tag_valid_o(tv1), .busy_o(bs1), .done_o(dn1)
    );

    assign ov  = {rnd, en, sel, xdb, xkb, xke, xee, dr, cv, tv, dn, bs};
    assign ov1 = {rnd1, en1, sel1, xdb1, xkb1, xke1, xee1, dr1, cv1, tv1, dn1, bs1};

    function automatic exp_t mk(input int r, input bit e, s, xd, xk, ke, xe, d, c, t, n, b);
        return {4'(r), e, s, xd, xk, ke, xe, d, c, t, n, b};
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input bit s, input bit d, input exp_t e);
        vec_t v;
        v.st = s;
        v.dv = d;
        v.e  = e;
        tbl.push_back(v);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        st   = 1'b0;
        dv   = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int nr, nc, done_at;
        exp_t wt;
        wt = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        // Expected NB=4 timeline, data_valid held high in WAIT states.
        for (int r = 0; r < 12; r++) add(0, 1, mk(r, 1, r != 0, 0, 0, r == 11, 0, 0, 0, 0, 0, 1));
        add(0, 1, wt);
        // start pulsed during AD must be ignored
        for (int r = 6; r < 12; r++)
            add(r == 8 || r == 9, 1, mk(r, 1, 1, r == 6, 0, 0, r == 11, r == 6, 0, 0, 0, 1));
        add(0, 1, wt);
        // data_valid dropped mid-PT block has no effect
        for (int b = 0; b < 3; b++) begin
            for (int r = 6; r < 12; r++)
                add(0, 0, mk(r, 1, 1, r == 6, 0, 0, 0, r == 6, r == 6, 0, 0, 1));
            add(0, 1, wt);
        end
        for (int r = 0; r < 12; r++)
            add(0, 1, mk(r, 1, 1, r == 0, r == 0, r == 11, 0, r == 0, r == 0, 0, 0, 1));
        add(1, 1, mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1));
        add(0, 1, '0);

        repeat (2) @(negedge clk);
        chk("reset_state", int'(ov), 0);
        rstn = 1'b1;
        @(negedge clk);
        chk("idle_state", int'(ov), 0);

        // Full NB=4 message.
        st = 1'b1;
        dv = 1'b1;
        @(negedge clk);
        st = 1'b0;
        nr = 0;
        nc = 0;
        done_at = -1;
        for (int i = 0; i < tbl.size(); i++) begin
            chk($sformatf("vec%0d", i), int'(ov), int'(tbl[i].e));
            nr += int'(dr);
            nc += int'(cv);
            if (dn && done_at < 0) done_at = i + 1;
            st = tbl[i].st;
            dv = tbl[i].dv;
            @(negedge clk);
        end
        chk("ready_pulses", nr, 5);
        chk("cipher_pulses", nc, 4);
        chk("done_cycle", done_at, 54);

        // Asynchronous reset during INIT at rnd=5, then restart.
        do_reset();
        st = 1'b1;
        dv = 1'b1;
        @(negedge clk);
        st = 1'b0;
        repeat (5) @(negedge clk);
        chk("init_rnd5", int'(rnd), 5);
        #2 rstn = 1'b0;
        #1 chk("async_reset_outs", int'(ov), 0);
        chk("async_reset_busy", int'(bs), 0);
        @(negedge clk);
        rstn = 1'b1;
        st = 1'b1;
        @(negedge clk);
        st = 1'b0;
        chk("restart_first", int'(ov), int'(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)));

        // data_valid held low for 10 cycles in WAIT_PT.
        do_reset();
        st = 1'b1;
        dv = 1'b1;
        @(negedge clk);
        st = 1'b0;
        repeat (13) @(negedge clk);
        chk("ad_first", int'(ov), int'(mk(6, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 1)));
        dv = 1'b0;
        repeat (6) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("wait_hold%0d", k), int'(ov), int'(wt));
            if (k < 9) @(negedge clk);
        end
        dv = 1'b1;
        @(negedge clk);
        chk("pt_resume", int'(ov), int'(mk(6, 1, 1, 1, 0, 0, 0, 1, 1, 0, 0, 1)));
        do_reset();

        // NB_PT_BLOCKS=1: WAIT_PT goes straight to FINAL.
        st1 = 1'b1;
        dv1 = 1'b1;
        @(negedge clk);
        st1 = 1'b0;
        nr = 0;
        nc = 0;
        done_at = -1;
        for (int c = 1; c <= 35; c++) begin
            if (c == 19) chk("nb1_ad_last", int'(ov1), int'(mk(11, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1)));
            if (c == 20) chk("nb1_wait_pt", int'(ov1), int'(wt));
            if (c == 21) chk("nb1_final_first", int'(ov1), int'(mk(0, 1, 1, 1, 1, 0, 0, 1, 1, 0, 0, 1)));
            nr += int'(dr1);
            nc += int'(cv1);
            if (dn1 && done_at < 0) done_at = c;
            @(negedge clk);
        end
        chk("nb1_ready_pulses", nr, 2);
        chk("nb1_cipher_pulses", nc, 1);
        chk("nb1_done_cycle", done_at, 33);
        chk("nb1_idle", int'(ov1), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
